// File: rtl/cam_soc_nios2_qsys_0_cpu_debug_cmd_sync.sv
// Debug command synchronizer: carries virtual-JTAG update-IR/update-DR events
// into the clk domain, holds one pending command for the core and issues a
// one-cycle one-hot accept pulse per channel.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no command pending, waiting for an update-DR event
// PEND  | command held in jdo/cmd_ch, cmd_valid high until accepted
module cam_soc_nios2_qsys_0_cpu_debug_cmd_sync #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int ACTION_BIT  = DATA_W - 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ch,
  output logic [DATA_W-1:0] jdo,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic              bad_ch,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t state_q, state_d;

  // index 0 carries update-IR, index 1 carries update-DR
  logic [1:0]             async_in;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] prime_q;
  logic [1:0]             sync_last;
  logic [1:0]             last_q;
  logic [1:0]             arm_q;
  logic [1:0]             rise_q;

  logic                   rise_uir;
  logic                   rise_udr;
  logic [IR_W-1:0]        ir_q;
  logic [IR_W-1:0]        new_ch;
  logic                   ch_ok;
  logic                   capture;
  logic                   accept;
  logic                   drop_bad;
  logic                   overrun;
  logic [NUM_CH-1:0]      onehot;

  assign async_in = {vs_udr, vs_uir};

  // Expose the last synchronizer stage of each input.
  always_comb begin
    sync_last = '0;
    for (int i = 0; i < 2; i++) sync_last[i] = sync_q[i][SYNC_STAGES-1];
  end

  // Synchronizers plus registered rising-edge detect. prime_q marks when the
  // chain holds real samples; an input is only armed once it has been seen
  // low after that, so a level already high at reset release is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q[0] <= '0;
      sync_q[1] <= '0;
      prime_q   <= '0;
      last_q    <= '0;
      arm_q     <= '0;
      rise_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      last_q  <= sync_last;
      arm_q   <= arm_q | ({2{prime_q[SYNC_STAGES-1]}} & ~sync_last);
      rise_q  <= sync_last & ~last_q & arm_q;
    end
  end

  assign rise_uir = rise_q[0];
  assign rise_udr = rise_q[1];

  // A same-cycle update-IR overrides the stored instruction.
  assign new_ch = rise_uir ? ir_in : ir_q;
  assign ch_ok  = (32'(new_ch) < NUM_CH);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    accept   = 1'b0;
    drop_bad = 1'b0;
    overrun  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_udr) begin
          if (ch_ok) begin
            capture = 1'b1;
            state_d = PEND;
          end else begin
            drop_bad = 1'b1;
          end
        end
      end
      PEND: begin
        if (cmd_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
          if (rise_udr) begin
            if (ch_ok) begin
              capture = 1'b1;
              state_d = PEND;
            end else begin
              drop_bad = 1'b1;
            end
          end
        end else if (rise_udr) begin
          overrun = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction, captured command and overrun counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q        <= '0;
      jdo         <= '0;
      cmd_ch      <= '0;
      overrun_cnt <= '0;
    end else begin
      if (rise_uir) ir_q <= ir_in;
      if (capture) begin
        jdo    <= sr;
        cmd_ch <= new_ch;
      end
      if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  // Accept pulses are combinational so they always coincide with cmd_valid.
  assign onehot         = NUM_CH'(1) << cmd_ch;
  assign cmd_valid      = (state_q == PEND);
  assign take_action    = (accept &&  jdo[ACTION_BIT]) ? onehot : '0;
  assign take_no_action = (accept && !jdo[ACTION_BIT]) ? onehot : '0;
  assign bad_ch         = drop_bad;

endmodule

// File: tb/tb_cam_soc_nios2_qsys_0_cpu_debug_cmd_sync.sv
module tb_cam_soc_nios2_qsys_0_cpu_debug_cmd_sync;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_uir, vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;

  logic        cv0, bad0, cv1, bad1;
  logic [1:0]  ch0, ch1;
  logic [37:0] jdo0, jdo1;
  logic [3:0]  ta0, tna0;
  logic [2:0]  ta1, tna1;
  logic [7:0]  ovr0, ovr1;

  int tests  = 0;
  int failed = 0;

  localparam logic [37:0] DA = 38'h20_0000_00AB;
  localparam logic [37:0] DB = 38'h00_1234_5678;
  localparam logic [37:0] DC = 38'h3F_0000_0001;
  localparam logic [37:0] DD = 38'h00_0000_0C0C;
  localparam logic [37:0] DE = 38'h15_5555_AAAA;

  always #5 clk = ~clk;

  cam_soc_nios2_qsys_0_cpu_debug_cmd_sync u0 (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready),
    .cmd_valid(cv0), .cmd_ch(ch0), .jdo(jdo0), .take_action(ta0),
    .take_no_action(tna0), .bad_ch(bad0), .overrun_cnt(ovr0)
  );

  cam_soc_nios2_qsys_0_cpu_debug_cmd_sync #(.NUM_CH(3)) u1 (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready),
    .cmd_valid(cv1), .cmd_ch(ch1), .jdo(jdo1), .take_action(ta1),
    .take_no_action(tna1), .bad_ch(bad1), .overrun_cnt(ovr1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_uir(input logic [1:0] ch);
    ir_in  = ch;
    vs_uir = 1'b1;
    tick(6);
    vs_uir = 1'b0;
    tick(6);
  endtask

  task automatic pulse_udr(input logic [37:0] d);
    sr     = d;
    vs_udr = 1'b1;
    tick(6);
    vs_udr = 1'b0;
    tick(6);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cv"},   64'(cv0),  64'd0);
    chk({tag, "_jdo"},  64'(jdo0), 64'd0);
    chk({tag, "_ch"},   64'(ch0),  64'd0);
    chk({tag, "_ta"},   64'(ta0),  64'd0);
    chk({tag, "_tna"},  64'(tna0), 64'd0);
    chk({tag, "_bad"},  64'(bad0), 64'd0);
    chk({tag, "_ovr"},  64'(ovr0), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    vs_uir    = 1'b0;
    vs_udr    = 1'b0;
    ir_in     = 2'd0;
    sr        = '0;
    cmd_ready = 1'b0;
    tick(3);
    chk_zero("reset");
    reset_n = 1'b1;
    tick(8);

    // basic command with exact latency and level hold
    pulse_uir(2'd1);
    cmd_ready = 1'b1;
    sr        = DA;
    vs_udr    = 1'b1;
    tick(4);
    chk("lat_edge4_cv", 64'(cv0), 64'd0);
    tick(1);
    chk("lat_edge5_cv", 64'(cv0), 64'd1);
    chk("basic_ta",     64'(ta0), 64'h2);
    chk("basic_tna",    64'(tna0), 64'h0);
    chk("basic_jdo",    64'(jdo0), 64'(DA));
    chk("basic_ch",     64'(ch0), 64'd1);
    tick(1);
    chk("basic_cv_drop", 64'(cv0), 64'd0);
    chk("basic_ta_once", 64'(ta0), 64'h0);
    tick(10);
    chk("hold_no_recap", 64'(cv0), 64'd0);
    vs_udr = 1'b0;
    tick(6);

    // backpressure: three overruns, then a single no-action pulse
    cmd_ready = 1'b0;
    pulse_uir(2'd2);
    pulse_udr(DB);
    chk("bp_cv",  64'(cv0), 64'd1);
    chk("bp_ch",  64'(ch0), 64'd2);
    pulse_udr(DC);
    pulse_udr(DD);
    pulse_udr(DE);
    chk("bp_jdo",   64'(jdo0), 64'(DB));
    chk("bp_ch2",   64'(ch0),  64'd2);
    chk("bp_ovr",   64'(ovr0), 64'd3);
    chk("bp_nopul", 64'({ta0, tna0}), 64'h0);
    cmd_ready = 1'b1;
    #1;
    chk("bp_tna", 64'(tna0), 64'h4);
    chk("bp_ta",  64'(ta0),  64'h0);
    tick(1);
    chk("bp_cv_drop", 64'(cv0),  64'd0);
    chk("bp_tna_end", 64'(tna0), 64'h0);

    // acceptance coinciding with a new capture
    cmd_ready = 1'b0;
    pulse_udr(DC);
    chk("sim_pend", 64'(cv0), 64'd1);
    sr     = DD;
    vs_udr = 1'b1;
    tick(4);
    cmd_ready = 1'b1;
    #1;
    chk("sim_old_ta",  64'(ta0),  64'h4);
    chk("sim_old_tna", 64'(tna0), 64'h0);
    tick(1);
    chk("sim_cv_stay", 64'(cv0),  64'd1);
    chk("sim_new_jdo", 64'(jdo0), 64'(DD));
    chk("sim_new_tna", 64'(tna0), 64'h4);
    chk("sim_ovr",     64'(ovr0), 64'd3);
    tick(1);
    chk("sim_cv_end", 64'(cv0), 64'd0);
    vs_udr = 1'b0;
    tick(6);

    // out-of-range channel on the three-channel instance
    reset_n = 1'b0;
    tick(2);
    reset_n   = 1'b1;
    cmd_ready = 1'b0;
    tick(8);
    pulse_uir(2'd3);
    sr     = DE;
    vs_udr = 1'b1;
    tick(4);
    chk("oor_bad1",  64'(bad1), 64'd1);
    chk("oor_bad0",  64'(bad0), 64'd0);
    tick(1);
    chk("oor_bad1_once", 64'(bad1), 64'd0);
    chk("oor_cv1",   64'(cv1),  64'd0);
    chk("oor_jdo1",  64'(jdo1), 64'd0);
    chk("oor_cv0",   64'(cv0),  64'd1);
    chk("oor_ch0",   64'(ch0),  64'd3);
    vs_udr = 1'b0;
    tick(6);

    // reset while pending, with vs_udr held high across release
    chk("rst_pend_cv", 64'(cv0), 64'd1);
    tick(1);
    reset_n   = 1'b0;
    cmd_ready = 1'b1;
    vs_udr    = 1'b1;
    sr        = DB;
    #1;
    chk_zero("rst_pend");
    tick(3);
    reset_n = 1'b1;
    tick(15);
    chk("rel_no_cap_cv",  64'(cv0),  64'd0);
    chk("rel_no_cap_jdo", 64'(jdo0), 64'd0);
    chk("rel_no_pulse",   64'({ta0, tna0}), 64'h0);
    cmd_ready = 1'b0;
    vs_udr    = 1'b0;
    tick(6);
    pulse_udr(DB);
    chk("rearm_cv",  64'(cv0),  64'd1);
    chk("rearm_jdo", 64'(jdo0), 64'(DB));
    chk("rearm_ch",  64'(ch0),  64'd0);

    // overrun counter saturation
    for (int i = 0; i < 300; i++) begin
      sr     = DA;
      vs_udr = 1'b1;
      tick(5);
      vs_udr = 1'b0;
      tick(5);
      if (i == 253) chk("sat_254", 64'(ovr0), 64'd254);
    end
    chk("sat_ovr", 64'(ovr0), 64'd255);
    chk("sat_jdo", 64'(jdo0), 64'(DB));
    chk("sat_cv",  64'(cv0),  64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
